wca_duc_channel_scheduler: RTL and testbench

Time-shares one DUC interpolation datapath (CIC + CORDIC) among up to four baseband channels. Each channel has its own interpolation rate. The block divides the common IF strobe per channel to raise sample requests, then grants the shared datapath to one channel per slot using round-robin arbitration. It sits between the per-channel rate/config registers and the shared DUC pipeline. It replaces the single fixed strobe generator when more than one channel is built.

---
 rtl/wca_duc_pkg.sv | 12 +
 rtl/wca_rr_arbiter.sv | 23 ++
 rtl/wca_duc_channel_scheduler.sv | 117 +++++++++++
 tb/tb_wca_duc_channel_scheduler.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/wca_duc_pkg.sv
// Shared definitions for the DUC channel scheduler: channel limits, index-width
// helper and the packed-rate slice used by the per-channel dividers.
package wca_duc_pkg;
  localparam int MAX_NCHAN = 4;

  function automatic int idx_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction
endpackage

// Channel ch's rate inside a packed per-channel vector; channel 0 sits in the LSBs.
`define WCA_RATE_OF(v, ch, w) v[(ch)*(w) +: (w)]

// File: rtl/wca_rr_arbiter.sv
// Combinational round-robin pick: the first requesting channel at or after i_ptr,
// wrapping modulo NCHAN.
module wca_rr_arbiter #(
  parameter int NCHAN = 2,
  parameter int IDX_W = 2
) (
  input  logic [NCHAN-1:0] i_req,
  input  logic [IDX_W-1:0] i_ptr,
  output logic             o_any,
  output logic [IDX_W-1:0] o_idx
);
  // Walk the offsets from farthest to nearest so the nearest requester wins.
  always_comb begin
    o_any = 1'b0;
    o_idx = '0;
    for (int k = NCHAN - 1; k >= 0; k--) begin
      if (i_req[(int'(i_ptr) + k) % NCHAN]) begin
        o_any = 1'b1;
        o_idx = IDX_W'((int'(i_ptr) + k) % NCHAN);
      end
    end
  end
endmodule

// File: rtl/wca_duc_channel_scheduler.sv
// Shares one DUC interpolation datapath among NCHAN channels: per-channel strobe
// dividers raise requests, a round-robin arbiter grants one slot per clock.
module wca_duc_channel_scheduler
  import wca_duc_pkg::*;
#(
  parameter int NCHAN  = 2,
  parameter int RATE_W = 10,
  parameter int IDX_W  = 2
) (
  input  logic                    i_clock,
  input  logic                    i_reset,
  input  logic                    i_enable,
  input  logic                    i_strobe_if,
  input  logic [NCHAN*RATE_W-1:0] i_rate_interp,
  input  logic [NCHAN-1:0]        i_rate_we,
  input  logic [NCHAN-1:0]        i_chan_enable,
  input  logic                    i_busy,
  input  logic [NCHAN-1:0]        i_overrun_clr,
  output logic                    o_grant_valid,
  output logic [IDX_W-1:0]        o_grant_chan,
  output logic [NCHAN-1:0]        o_strobe_cic,
  output logic [NCHAN-1:0]        o_pending,
  output logic [NCHAN-1:0]        o_overrun
);
  if (NCHAN < 2 || NCHAN > MAX_NCHAN) begin : g_bad_nchan
    $error("wca_duc_channel_scheduler: NCHAN out of range");
  end
  if (IDX_W < idx_w(NCHAN)) begin : g_bad_idx_w
    $error("wca_duc_channel_scheduler: IDX_W too narrow for NCHAN");
  end

  logic [NCHAN-1:0] w_req;
  logic [NCHAN-1:0] w_arb_req;
  logic [NCHAN-1:0] w_hit;
  logic [NCHAN-1:0] w_ovr_set;
  logic             w_arb_any;
  logic [IDX_W-1:0] w_arb_idx;
  logic             w_go;
  logic [IDX_W-1:0] w_rr_next;

  logic             r_grant_valid;
  logic [IDX_W-1:0] r_grant_chan;
  logic [NCHAN-1:0] r_strobe_cic;
  logic [NCHAN-1:0] r_pending;
  logic [NCHAN-1:0] r_overrun;
  logic [IDX_W-1:0] r_rr_ptr;

  // Per-channel IF-strobe dividers; rate 0 behaves as rate 1.
  for (genvar g = 0; g < NCHAN; g++) begin : g_div
    logic [RATE_W-1:0] r_cnt;
    logic [RATE_W-1:0] w_rate;
    logic [RATE_W-1:0] w_eff;
    logic              w_term;

    assign w_rate   = `WCA_RATE_OF(i_rate_interp, g, RATE_W);
    assign w_eff    = (w_rate == '0) ? RATE_W'(1) : w_rate;
    assign w_term   = (r_cnt >= w_eff);
    assign w_req[g] = i_enable & i_chan_enable[g] & ~i_rate_we[g] & i_strobe_if & w_term;

    always_ff @(posedge i_clock) begin
      if (i_reset || !i_enable || !i_chan_enable[g] || i_rate_we[g])
        r_cnt <= RATE_W'(1);
      else if (i_strobe_if)
        r_cnt <= w_term ? RATE_W'(1) : r_cnt + 1'b1;
    end
  end

  assign w_arb_req = r_pending & i_chan_enable;

  wca_rr_arbiter #(
    .NCHAN (NCHAN),
    .IDX_W (IDX_W)
  ) u_arb (
    .i_req (w_arb_req),
    .i_ptr (r_rr_ptr),
    .o_any (w_arb_any),
    .o_idx (w_arb_idx)
  );

  assign w_go      = i_enable & ~i_busy & w_arb_any;
  assign w_hit     = w_go ? (NCHAN'(1) << w_arb_idx) : '0;
  assign w_rr_next = IDX_W'((int'(w_arb_idx) + 1) % NCHAN);
  // A grant in the same cycle absorbs a fresh request without loss.
  assign w_ovr_set = w_req & r_pending & ~w_hit;

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_grant_valid <= 1'b0;
      r_grant_chan  <= '0;
      r_strobe_cic  <= '0;
      r_pending     <= '0;
      r_overrun     <= '0;
      r_rr_ptr      <= '0;
    end else if (!i_enable) begin
      r_grant_valid <= 1'b0;
      r_strobe_cic  <= '0;
      r_pending     <= '0;
      r_rr_ptr      <= '0;
      r_overrun     <= r_overrun & ~i_overrun_clr;
    end else begin
      r_grant_valid <= w_go;
      r_strobe_cic  <= w_hit;
      if (w_go) begin
        r_grant_chan <= w_arb_idx;
        r_rr_ptr     <= w_rr_next;
      end
      r_pending <= ((r_pending & ~w_hit) | w_req) & i_chan_enable & ~i_rate_we;
      r_overrun <= (r_overrun & ~i_overrun_clr) | w_ovr_set;
    end
  end

  assign o_grant_valid = r_grant_valid;
  assign o_grant_chan  = r_grant_chan;
  assign o_strobe_cic  = r_strobe_cic;
  assign o_pending     = r_pending;
  assign o_overrun     = r_overrun;
endmodule

// File: tb/tb_wca_duc_channel_scheduler.sv
// Bench for wca_duc_channel_scheduler: expected grants (cycle, channel) are queued
// when stimulus is driven and matched by a negedge monitor.
module tb_wca_duc_channel_scheduler;
  localparam int NCHAN = 2, RATE_W = 10, IDX_W = 2;

  logic                    clk = 1'b0;
  logic                    reset, enable, strobe_if, busy;
  logic [NCHAN*RATE_W-1:0] rate_interp;
  logic [NCHAN-1:0]        rate_we, chan_enable, overrun_clr;
  logic                    grant_valid;
  logic [IDX_W-1:0]        grant_chan;
  logic [NCHAN-1:0]        strobe_cic, pending, overrun;

  typedef struct { int cyc; int chan; } exp_t;
  exp_t sb[$];
  int   compared = 0, mismatched = 0, cyc = 0;
  bit   mon_on = 1'b0;

  wca_duc_channel_scheduler #(.NCHAN(NCHAN), .RATE_W(RATE_W), .IDX_W(IDX_W)) dut (
    .i_clock       (clk),
    .i_reset       (reset),
    .i_enable      (enable),
    .i_strobe_if   (strobe_if),
    .i_rate_interp (rate_interp),
    .i_rate_we     (rate_we),
    .i_chan_enable (chan_enable),
    .i_busy        (busy),
    .i_overrun_clr (overrun_clr),
    .o_grant_valid (grant_valid),
    .o_grant_chan  (grant_chan),
    .o_strobe_cic  (strobe_cic),
    .o_pending     (pending),
    .o_overrun     (overrun)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Grant monitor: every grant must match the head of the scoreboard in cycle and channel.
  always @(negedge clk) begin
    if (mon_on) begin
      if (grant_valid === 1'b1) begin
        compared++;
        if (sb.size() == 0) begin
          mismatched++;
          $display("FAIL grant_unexpected cyc=%0d got chan=%0d strobe=%b, expected no grant", cyc, grant_chan, strobe_cic);
        end else begin
          exp_t e;
          logic [NCHAN-1:0] oh;
          e  = sb.pop_front();
          oh = '0;
          oh[e.chan] = 1'b1;
          if (e.cyc != cyc || int'(grant_chan) != e.chan || strobe_cic !== oh) begin
            mismatched++;
            $display("FAIL grant cyc=%0d chan=%0d strobe=%b, expected cyc=%0d chan=%0d strobe=%b",
                     cyc, grant_chan, strobe_cic, e.cyc, e.chan, oh);
          end
        end
      end else begin
        compared++;
        if (grant_valid !== 1'b0 || strobe_cic !== '0) begin
          mismatched++;
          $display("FAIL idle_outputs cyc=%0d grant_valid=%b strobe=%b, expected 0/00", cyc, grant_valid, strobe_cic);
        end else if (sb.size() > 0 && sb[0].cyc <= cyc) begin
          mismatched++;
          $display("FAIL grant_missing cyc=%0d got none, expected chan=%0d at cyc=%0d", cyc, sb[0].chan, sb[0].cyc);
          void'(sb.pop_front());
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input int c, input int ch);
    exp_t e;
    e.cyc  = c;
    e.chan = ch;
    sb.push_back(e);
  endtask

  task automatic set_rates(input int r0, input int r1);
    rate_interp = {RATE_W'(r1), RATE_W'(r0)};
  endtask

  task automatic do_reset();
    reset = 1'b1; enable = 1'b1; strobe_if = 1'b0; busy = 1'b0;
    rate_we = '0; overrun_clr = '0; chan_enable = '1;
    tick(); tick();
    reset = 1'b0;
    tick();
  endtask

  // One strobe, then idle clocks so strobes land every (1+gap) clocks.
  task automatic strobe_gap(input int gap);
    strobe_if = 1'b1;
    tick();
    strobe_if = 1'b0;
    for (int i = 0; i < gap; i++) tick();
  endtask

  task automatic test_reset();
    set_rates(1, 1);
    reset = 1'b1; enable = 1'b1; busy = 1'b0; rate_we = '0; overrun_clr = '0; chan_enable = '1;
    strobe_if = 1'b1;
    tick(); tick(); tick();
    strobe_if = 1'b0;
    compared++; if (grant_valid !== 1'b0) begin mismatched++; $display("FAIL reset_grant_valid got=%b exp=0", grant_valid); end
    compared++; if (grant_chan !== '0)    begin mismatched++; $display("FAIL reset_grant_chan got=%0d exp=0", grant_chan); end
    compared++; if (strobe_cic !== '0)    begin mismatched++; $display("FAIL reset_strobe_cic got=%b exp=00", strobe_cic); end
    compared++; if (pending !== '0)       begin mismatched++; $display("FAIL reset_pending got=%b exp=00", pending); end
    compared++; if (overrun !== '0)       begin mismatched++; $display("FAIL reset_overrun got=%b exp=00", overrun); end
    reset = 1'b0;
    tick();
    mon_on = 1'b1;
  endtask

  task automatic test_rates();
    do_reset();
    set_rates(4, 2);
    for (int k = 1; k <= 8; k++) begin
      if (k % 4 == 0) begin push(cyc + 2, 0); push(cyc + 3, 1); end
      else if (k % 2 == 0) push(cyc + 2, 1);
      strobe_gap(2);
    end
    tick(); tick();
    compared++; if (overrun !== '0) begin mismatched++; $display("FAIL rates_overrun got=%b exp=00", overrun); end
    compared++; if (pending !== '0) begin mismatched++; $display("FAIL rates_pending got=%b exp=00", pending); end
  endtask

  task automatic test_simultaneous();
    do_reset();
    set_rates(1, 1);
    for (int k = 0; k < 2; k++) begin
      push(cyc + 2, 0); push(cyc + 3, 1);
      strobe_gap(4);
    end
    compared++; if (pending !== '0) begin mismatched++; $display("FAIL simul_pending got=%b exp=00", pending); end
  endtask

  task automatic test_busy_overrun();
    do_reset();
    set_rates(1, 1);
    busy = 1'b1;
    for (int k = 0; k < 5; k++) strobe_gap(1);
    compared++; if (pending !== 2'b11) begin mismatched++; $display("FAIL busy_pending got=%b exp=11", pending); end
    compared++; if (overrun !== 2'b11) begin mismatched++; $display("FAIL busy_overrun got=%b exp=11", overrun); end
    busy = 1'b0;
    push(cyc + 1, 0); push(cyc + 2, 1);
    tick(); tick(); tick();
    compared++; if (pending !== '0)    begin mismatched++; $display("FAIL busy_drain_pending got=%b exp=00", pending); end
    compared++; if (overrun !== 2'b11) begin mismatched++; $display("FAIL busy_overrun_sticky got=%b exp=11", overrun); end
    overrun_clr = 2'b01; tick(); overrun_clr = '0;
    compared++; if (overrun !== 2'b10) begin mismatched++; $display("FAIL overrun_clr0 got=%b exp=10", overrun); end
    overrun_clr = 2'b10; tick(); overrun_clr = '0;
    compared++; if (overrun !== 2'b00) begin mismatched++; $display("FAIL overrun_clr1 got=%b exp=00", overrun); end
  endtask

  task automatic test_rate_we();
    do_reset();
    chan_enable = 2'b01;
    set_rates(3, 1);
    strobe_gap(2);
    strobe_gap(2);
    rate_we = 2'b01; strobe_if = 1'b1;
    tick();
    rate_we = '0; strobe_if = 1'b0;
    compared++; if (pending !== '0) begin mismatched++; $display("FAIL rate_we_pending got=%b exp=00", pending); end
    tick(); tick();
    strobe_gap(2);
    strobe_gap(2);
    push(cyc + 2, 0);
    strobe_gap(3);
    compared++; if (overrun !== '0) begin mismatched++; $display("FAIL rate_we_overrun got=%b exp=00", overrun); end
  endtask

  task automatic test_rate_zero();
    do_reset();
    chan_enable = 2'b10;
    set_rates(1, 0);
    for (int k = 0; k < 4; k++) begin push(cyc + 2, 1); strobe_gap(2); end
    set_rates(1, 1);
    for (int k = 0; k < 2; k++) begin push(cyc + 2, 1); strobe_gap(2); end
    tick();
    compared++; if (overrun !== '0) begin mismatched++; $display("FAIL rate_zero_overrun got=%b exp=00", overrun); end
  endtask

  task automatic test_inflight(input bit use_reset);
    logic [NCHAN-1:0] exp_ovr;
    do_reset();
    set_rates(1, 1);
    busy = 1'b1;
    strobe_gap(1);
    strobe_gap(1);
    busy = 1'b0;
    push(cyc + 1, 0);
    tick();
    if (use_reset) reset = 1'b1; else enable = 1'b0;
    tick();
    exp_ovr = use_reset ? 2'b00 : 2'b11;
    compared++; if (grant_valid !== 1'b0) begin mismatched++; $display("FAIL inflight_grant_valid rst=%0d got=%b exp=0", use_reset, grant_valid); end
    compared++; if (pending !== '0)       begin mismatched++; $display("FAIL inflight_pending rst=%0d got=%b exp=00", use_reset, pending); end
    compared++; if (overrun !== exp_ovr)  begin mismatched++; $display("FAIL inflight_overrun rst=%0d got=%b exp=%b", use_reset, overrun, exp_ovr); end
    reset = 1'b0; enable = 1'b1;
    tick(); tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_rates();
    test_simultaneous();
    test_busy_overrun();
    test_rate_we();
    test_rate_zero();
    test_inflight(1'b1);
    test_inflight(1'b0);
    tick(); tick();
    compared++;
    if (sb.size() != 0) begin
      mismatched++;
      $display("FAIL scoreboard_leftover got=%0d entries exp=0", sb.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
